cpu_boot_ctrl: RTL

Sequencer that owns the external memory ports and `enable` of the 5-stage RISC-V `cpu`. On `start` it runs the test session in a fixed order:
- stream a program from the host into instruction memory;
- stream initial data into data memory;
- run the core for a programmed number of cycles;
- stream data memory back to the host.

It sits between the testbench/host link and the `cpu` top. The `cpu` is never enabled while its memories are being written or read back.

---
 rtl/cpu_boot_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_boot_ctrl.sv
// Boot sequencer for the 5-stage cpu: load imem, load dmem, run N cycles, dump dmem.
// Define BOOT_CTRL_DUMP_EN to include the dmem readback phase; otherwise RUN ends in DONE.
module cpu_boot_ctrl #(
    parameter int IMEM_DEPTH = 128,
    parameter int DMEM_DEPTH = 128,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [15:0]      imem_words,
    input  logic [15:0]      dmem_words,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [63:0]      host_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [63:0]      dump_data,
    output logic             enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_dbg_o
);

    // Host and dump links are valid/ready: a word moves on an edge where both are high;
    // the producer keeps valid and data steady until that edge.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_I   = 3'd1,
        LOAD_D   = 3'd2,
        RUN      = 3'd3,
        DUMP_RD  = 3'd4,
        DUMP_CAP = 3'd5,
        DUMP_OUT = 3'd6,
        DONE     = 3'd7
    } state_t;

    localparam logic [15:0] IMEM_MAX = 16'(IMEM_DEPTH);
    localparam logic [15:0] DMEM_MAX = 16'(DMEM_DEPTH);

    state_t           state_q, state_d;
    logic [15:0]      idx_q, idx_d;
    logic [15:0]      icnt_q, icnt_d;
    logic [15:0]      dcnt_q, dcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      imem_sat, dmem_sat;
    logic             run_exit;

    assign imem_sat = (imem_words > IMEM_MAX) ? IMEM_MAX : imem_words;
    assign dmem_sat = (dmem_words > DMEM_MAX) ? DMEM_MAX : dmem_words;

    assign ren_ext     = 1'b0;
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign state_dbg_o = state_q;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            icnt_q  <= '0;
            dcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            icnt_q  <= icnt_d;
            dcnt_q  <= dcnt_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BOOT_CTRL_DUMP_EN
    logic [63:0] dump_q, dump_d;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            dump_q <= '0;
        end else begin
            dump_q <= dump_d;
        end
    end

    assign dump_data = dump_q;
`else
    logic unused_dump;

    assign unused_dump = ^{dump_ready, rdata_ext_2};
    assign dump_valid  = 1'b0;
    assign dump_data   = '0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        icnt_d      = icnt_q;
        dcnt_d      = dcnt_q;
        cnt_d       = cnt_q;
        run_exit    = 1'b0;
        host_ready  = 1'b0;
        enable      = 1'b0;
        addr_ext    = '0;
        wen_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        ren_ext_2   = 1'b0;
`ifdef BOOT_CTRL_DUMP_EN
        dump_valid  = 1'b0;
        dump_d      = dump_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    icnt_d = imem_sat;
                    dcnt_d = dmem_sat;
                    cnt_d  = run_cycles;
                    idx_d  = '0;
                    if (imem_sat != '0)      state_d = LOAD_I;
                    else if (dmem_sat != '0) state_d = LOAD_D;
                    else                     state_d = RUN;
                end
            end
            LOAD_I: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    wen_ext   = 1'b1;
                    addr_ext  = {46'b0, idx_q, 2'b00};
                    wdata_ext = host_data[31:0];
                    if (idx_q == icnt_q - 16'd1) begin
                        idx_d   = '0;
                        state_d = (dcnt_q != '0) ? LOAD_D : RUN;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            LOAD_D: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    wen_ext_2   = 1'b1;
                    addr_ext_2  = {45'b0, idx_q, 3'b000};
                    wdata_ext_2 = host_data;
                    if (idx_q == dcnt_q - 16'd1) begin
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            RUN: begin
                // A zero count spends one cycle here with enable low, then leaves.
                if (cnt_q != '0) begin
                    enable   = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    run_exit = (cnt_q == CNT_W'(1));
                end else begin
                    run_exit = 1'b1;
                end
                if (run_exit) begin
`ifdef BOOT_CTRL_DUMP_EN
                    idx_d   = '0;
                    state_d = (dcnt_q != '0) ? DUMP_RD : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef BOOT_CTRL_DUMP_EN
            DUMP_RD: begin
                ren_ext_2  = 1'b1;
                addr_ext_2 = {45'b0, idx_q, 3'b000};
                state_d    = DUMP_CAP;
            end
            DUMP_CAP: begin
                dump_d  = rdata_ext_2;
                state_d = DUMP_OUT;
            end
            DUMP_OUT: begin
                dump_valid = 1'b1;
                if (dump_ready) begin
                    if (idx_q == dcnt_q - 16'd1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = DUMP_RD;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule
